// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman core and its stream feeder:
// base codes, sequence lengths, result widths and the feeder state type.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int REF_LEN         = 64;
  localparam int QUERY_LEN       = 48;
  localparam int WIDTH_SCORE     = 8;
  localparam int WIDTH_POS_REF   = 7;
  localparam int WIDTH_POS_QUERY = 6;
  localparam int TIMEOUT         = 4095;

  localparam int ADDR_W = 6;
  localparam int BEAT_W = 7;
  localparam int WAIT_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/sw_seq_buffer.sv
// Reference and query base buffers: one shared write port and one
// combinational read port that returns both sequences at the same index.
module sw_seq_buffer
  import sw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [1:0]        rd_ref,
  output logic [1:0]        rd_query
);

  logic [1:0] ref_mem   [REF_LEN];
  logic [1:0] query_mem [QUERY_LEN];

  // NOTE: these buffers are cleared by reset on purpose, so a run started
  // straight after reset streams defined all-A sequences rather than X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REF_LEN; i++)   ref_mem[i]   <= BASE_A;
      for (int i = 0; i < QUERY_LEN; i++) query_mem[i] <= BASE_A;
    end else if (wr_en) begin
      if (!wr_sel)
        ref_mem[wr_addr] <= wr_data;
      else if (int'(wr_addr) < QUERY_LEN)
        query_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_ref   = ref_mem[rd_idx];
  assign rd_query = (int'(rd_idx) < QUERY_LEN) ? query_mem[rd_idx] : BASE_A;

endmodule

// File: rtl/sw_stream_feeder.sv
// Streams the stored reference/query pair into the scoring core as one
// valid burst, waits for finish (or times out) and hands the result to the host.
module sw_stream_feeder
  import sw_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [1:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       sw_valid,
  output logic [1:0]                 sw_data_ref,
  output logic [1:0]                 sw_data_query,
  input  logic                       sw_finish,
  input  logic [WIDTH_SCORE-1:0]     sw_max,
  input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH_SCORE-1:0]     res_max,
  output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
  output logic                       res_timeout
);

  feeder_state_t              state, state_d;
  logic [BEAT_W-1:0]          beat_cnt, beat_cnt_d;
  logic [WAIT_W-1:0]          wait_cnt, wait_cnt_d;
  logic                       busy_d, sw_valid_d, res_valid_d, res_timeout_d;
  logic [1:0]                 sw_data_ref_d, sw_data_query_d;
  logic [WIDTH_SCORE-1:0]     res_max_d;
  logic [WIDTH_POS_REF-1:0]   res_pos_ref_d;
  logic [WIDTH_POS_QUERY-1:0] res_pos_query_d;

  logic              buf_we;
  logic [ADDR_W-1:0] rd_idx;
  logic [1:0]        rd_ref, rd_query, next_ref, next_query;

  assign buf_we = wr_en && (state == IDLE);

  // The output registers are loaded with the beat that follows the one on the bus.
  assign rd_idx = (state == STREAM) ? beat_cnt[ADDR_W-1:0] + 6'd1 : '0;

  sw_seq_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (buf_we),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_idx   (rd_idx),
    .rd_ref   (rd_ref),
    .rd_query (rd_query)
  );

  // A write landing in the same cycle as start must reach beat 0, so bypass it.
  assign next_ref   = (buf_we && !wr_sel && wr_addr == rd_idx) ? wr_data : rd_ref;
  assign next_query = (buf_we && wr_sel && wr_addr == rd_idx && int'(rd_idx) < QUERY_LEN)
                      ? wr_data : rd_query;

  // NOTE: every signal gets a default first, so no path through the case
  // statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state;
    beat_cnt_d      = beat_cnt;
    wait_cnt_d      = wait_cnt;
    sw_valid_d      = 1'b0;
    sw_data_ref_d   = BASE_A;
    sw_data_query_d = BASE_A;
    res_max_d       = res_max;
    res_pos_ref_d   = res_pos_ref;
    res_pos_query_d = res_pos_query;
    res_timeout_d   = res_timeout;

    case (state)
      IDLE: begin
        if (start) begin
          state_d         = STREAM;
          beat_cnt_d      = '0;
          sw_valid_d      = 1'b1;
          sw_data_ref_d   = next_ref;
          sw_data_query_d = next_query;
        end
      end
      STREAM: begin
        if (beat_cnt == BEAT_W'(REF_LEN - 1)) begin
          state_d    = WAIT_RES;
          wait_cnt_d = '0;
        end else begin
          beat_cnt_d      = beat_cnt + 7'd1;
          sw_valid_d      = 1'b1;
          sw_data_ref_d   = next_ref;
          sw_data_query_d = next_query;
        end
      end
      WAIT_RES: begin
        wait_cnt_d = wait_cnt + 12'd1;
        if (sw_finish) begin
          state_d         = DONE;
          res_max_d       = sw_max;
          res_pos_ref_d   = sw_pos_ref;
          res_pos_query_d = sw_pos_query;
          res_timeout_d   = 1'b0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_d         = DONE;
          res_max_d       = '0;
          res_pos_ref_d   = '0;
          res_pos_query_d = '0;
          res_timeout_d   = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      sw_valid      <= 1'b0;
      sw_data_ref   <= BASE_A;
      sw_data_query <= BASE_A;
      res_valid     <= 1'b0;
      res_max       <= '0;
      res_pos_ref   <= '0;
      res_pos_query <= '0;
      res_timeout   <= 1'b0;
    end else begin
      state         <= state_d;
      beat_cnt      <= beat_cnt_d;
      wait_cnt      <= wait_cnt_d;
      busy          <= busy_d;
      sw_valid      <= sw_valid_d;
      sw_data_ref   <= sw_data_ref_d;
      sw_data_query <= sw_data_query_d;
      res_valid     <= res_valid_d;
      res_max       <= res_max_d;
      res_pos_ref   <= res_pos_ref_d;
      res_pos_query <= res_pos_query_d;
      res_timeout   <= res_timeout_d;
    end
  end

endmodule
